inst_fetch_responder: RTL and testbench

- Responder end of the IFU instruction-fetch handshake: accepts inst_req/inst_addr and returns a 128-bit fetch group with inst_valid, inst_count, uncache and exception status.
- Backed by a synchronous-read on-chip instruction RAM of 128-bit lines. Used in place of the icache/TLB path for bring-up and for standalone IFU verification.
- Two-stage pipeline: RAM read, then output register. Supports inst_cancel flush.

---
 rtl/inst_fetch_responder_pkg.sv | 19 +
 rtl/inst_fetch_rotate.sv | 19 +
 rtl/inst_fetch_responder.sv | 128 ++++++++++++
 tb/tb_inst_fetch_responder.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/inst_fetch_responder_pkg.sv
// Shared constants for the instruction-fetch responder: fetch-group geometry,
// the address-error exception code and the stall LFSR definition.
package inst_fetch_responder_pkg;

  localparam int FETCH_W = 128;
  localparam int SLOT_N  = 4;
  localparam int SLOT_W  = FETCH_W / SLOT_N;

  localparam logic [5:0] ECODE_ADEF = 6'h08;

  // x^8+x^6+x^5+x^4+1 as a left-shifting Fibonacci LFSR: feedback from bits 7,5,4,3
  localparam logic [7:0] LFSR_SEED = 8'hA5;
  localparam logic [7:0] LFSR_TAPS = 8'hB8;

  function automatic logic [7:0] lfsr_next(input logic [7:0] cur);
    return {cur[6:0], ^(cur & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/inst_fetch_rotate.sv
// Aligns a RAM line to the fetch address: rotates right by the starting word
// so slot 0 holds the addressed instruction, zero-fills the vacated upper
// slots and reports the number of valid slots minus one.
module inst_fetch_rotate
  import inst_fetch_responder_pkg::*;
(
  input  logic [FETCH_W-1:0] line,
  input  logic [1:0]         word,
  output logic [FETCH_W-1:0] group,
  output logic [1:0]         count
);

  // logical right shift gives the zero fill for free
  always_comb begin
    group = line >> (SLOT_W * int'(word));
    count = 2'(SLOT_N - 1) - word;
  end

endmodule

// File: rtl/inst_fetch_responder.sv
// Responder side of the IFU fetch handshake, backed by an on-chip RAM of
// 128-bit lines. Stage 1 issues the RAM read and checks the address; stage 2
// aligns the line into the registered response. Fixed latency of 2 cycles.
// Optional macro INST_RESP_STALL_EN adds LFSR-driven pseudo-random stalls on
// inst_addr_ok to exercise IFU retry paths.
module inst_fetch_responder
  import inst_fetch_responder_pkg::*;
#(
  parameter int          RAM_AW       = 12,
  parameter logic [31:0] BASE_ADDR    = 32'h1c000000,
  parameter logic [31:0] UNCACHE_BASE = 32'h1f000000,
  parameter logic [5:0]  ECODE_ADEF   = inst_fetch_responder_pkg::ECODE_ADEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                inst_req,
  input  logic [31:0]         inst_addr,
  input  logic                inst_cancel,
  output logic                inst_addr_ok,
  output logic [FETCH_W-1:0]  inst_rdata,
  output logic                inst_valid,
  output logic [1:0]          inst_count,
  output logic                inst_uncache,
  output logic [5:0]          inst_exccode,
  output logic                inst_exception,
  output logic                ram_en,
  output logic [RAM_AW-1:0]   ram_addr,
  input  logic [FETCH_W-1:0]  ram_rdata
);

  // RAM span in bytes; one extra bit so 16<<RAM_AW cannot wrap
  localparam logic [32:0] SPAN = 33'd16 << RAM_AW;

  logic        stall;
  logic        accept;
  logic        fault;
  logic [31:0] offset;

  logic        s1_valid;
  logic        s1_fault;
  logic [1:0]  s1_word;
  logic        s1_uncache;
  logic        s2_valid;

  logic [FETCH_W-1:0] aligned;
  logic [1:0]         aligned_count;

`ifdef INST_RESP_STALL_EN
  logic [7:0] lfsr;

  // free-running stall generator, restarts from the seed on reset
  always_ff @(posedge clk) begin
    if (reset) lfsr <= LFSR_SEED;
    else       lfsr <= lfsr_next(lfsr);
  end

  assign stall = lfsr[0] & lfsr[3];
`else
  assign stall = 1'b0;
`endif

  // handshake and address check in the accept cycle
  always_comb begin
    offset       = inst_addr - BASE_ADDR;
    fault        = (inst_addr[1:0] != 2'b00) | (inst_addr < BASE_ADDR) |
                   ({1'b0, offset} >= SPAN);
    inst_addr_ok = ~reset & ~inst_cancel & ~stall;
    accept       = inst_req & inst_addr_ok;
    ram_en       = accept & ~fault;
    ram_addr     = offset[RAM_AW+3:4];
  end

  // ---- stage 1: RAM read in flight ----
  always_ff @(posedge clk) begin
    if (reset) s1_valid <= 1'b0;
    else       s1_valid <= accept;
  end

  // side-band for the request whose RAM line arrives next cycle
  always_ff @(posedge clk) begin
    if (accept) begin
      s1_fault   <= fault;
      s1_word    <= inst_addr[3:2];
      s1_uncache <= (inst_addr >= UNCACHE_BASE);
    end
  end

  inst_fetch_rotate u_rotate (
    .line  (ram_rdata),
    .word  (s1_word),
    .group (aligned),
    .count (aligned_count)
  );

  // ---- stage 2: registered response ----
  always_ff @(posedge clk) begin
    if (reset) s2_valid <= 1'b0;
    else       s2_valid <= s1_valid & ~inst_cancel;
  end

  // response payload; a faulting fetch returns an empty group with ADEF
  always_ff @(posedge clk) begin
    if (reset) begin
      inst_rdata     <= '0;
      inst_count     <= 2'd0;
      inst_exception <= 1'b0;
      inst_exccode   <= 6'd0;
      inst_uncache   <= 1'b0;
    end else if (s1_valid) begin
      inst_uncache <= s1_uncache;
      if (s1_fault) begin
        inst_rdata     <= '0;
        inst_count     <= 2'd0;
        inst_exception <= 1'b1;
        inst_exccode   <= ECODE_ADEF;
      end else begin
        inst_rdata     <= aligned;
        inst_count     <= aligned_count;
        inst_exception <= 1'b0;
        inst_exccode   <= 6'd0;
      end
    end
  end

  // a cancel hides the response already sitting in the output register
  assign inst_valid = s2_valid & ~inst_cancel & ~reset;

endmodule

// File: tb/tb_inst_fetch_responder.sv
// Directed bench for inst_fetch_responder with a behavioural RAM model.
module tb_inst_fetch_responder;

  logic         clk = 1'b0;
  logic         reset;
  logic         inst_req;
  logic [31:0]  inst_addr;
  logic         inst_cancel;
  logic         inst_addr_ok;
  logic [127:0] inst_rdata;
  logic         inst_valid;
  logic [1:0]   inst_count;
  logic         inst_uncache;
  logic [5:0]   inst_exccode;
  logic         inst_exception;
  logic         ram_en;
  logic [11:0]  ram_addr;
  logic [127:0] ram_rdata = '0;

  int n_chk  = 0;
  int n_fail = 0;

  logic [127:0] mem [0:4095];

  inst_fetch_responder dut (
    .clk            (clk),
    .reset          (reset),
    .inst_req       (inst_req),
    .inst_addr      (inst_addr),
    .inst_cancel    (inst_cancel),
    .inst_addr_ok   (inst_addr_ok),
    .inst_rdata     (inst_rdata),
    .inst_valid     (inst_valid),
    .inst_count     (inst_count),
    .inst_uncache   (inst_uncache),
    .inst_exccode   (inst_exccode),
    .inst_exception (inst_exception),
    .ram_en         (ram_en),
    .ram_addr       (ram_addr),
    .ram_rdata      (ram_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_en) ram_rdata <= mem[ram_addr];
  end

  function automatic logic [31:0] iw(input int line, input int slot);
    return 32'hC0DE0000 | 32'(line << 4) | 32'(slot);
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    for (int k = 0; k < 4096; k++)
      mem[k] = {iw(k, 3), iw(k, 2), iw(k, 1), iw(k, 0)};

    reset = 1'b1; inst_req = 1'b0; inst_addr = 32'h0; inst_cancel = 1'b0;
    tick; tick;
    inst_req = 1'b1; inst_addr = 32'h1c000000; #1;
    chk("rst_addr_ok", 128'(inst_addr_ok), 128'(0));
    chk("rst_ram_en", 128'(ram_en), 128'(0));
    tick;
    chk("rst_valid", 128'(inst_valid), 128'(0));
    chk("rst_rdata", inst_rdata, 128'(0));
    chk("rst_count", 128'(inst_count), 128'(0));
    chk("rst_exc", 128'(inst_exception), 128'(0));
    chk("rst_code", 128'(inst_exccode), 128'(0));
    chk("rst_unc", 128'(inst_uncache), 128'(0));
    inst_req = 1'b0; reset = 1'b0;

`ifdef INST_RESP_STALL_EN
    begin
      logic [7:0] m;
      logic [1:0] hist;
      logic       exp_ok;
      m = 8'hA5; hist = 2'b00;
      for (int i = 0; i < 256; i++) begin
        inst_req = 1'b1; inst_addr = 32'h1c000000 + 32'(i % 64) * 4; #1;
        exp_ok = ~(m[0] & m[3]);
        chk("stall_addr_ok", 128'(inst_addr_ok), 128'(exp_ok));
        chk("stall_valid", 128'(inst_valid), 128'(hist[1]));
        hist = {hist[0], exp_ok};
        tick;
        m = {m[6:0], m[7] ^ m[5] ^ m[4] ^ m[3]};
      end
      inst_req = 1'b0;
    end
`else
    // aligned fetch
    tick;
    inst_req = 1'b1; inst_addr = 32'h1c000000; #1;
    chk("al_addr_ok", 128'(inst_addr_ok), 128'(1));
    chk("al_ram_en", 128'(ram_en), 128'(1));
    chk("al_ram_addr", 128'(ram_addr), 128'(0));
    tick;
    inst_req = 1'b0; #1;
    chk("al_valid_t1", 128'(inst_valid), 128'(0));
    tick;
    chk("al_valid", 128'(inst_valid), 128'(1));
    chk("al_rdata", inst_rdata, {iw(0, 3), iw(0, 2), iw(0, 1), iw(0, 0)});
    chk("al_count", 128'(inst_count), 128'(3));
    chk("al_exc", 128'(inst_exception), 128'(0));
    chk("al_unc", 128'(inst_uncache), 128'(0));
    tick;
    chk("al_valid_end", 128'(inst_valid), 128'(0));

    // back-to-back mid-line fetches
    inst_req = 1'b1; inst_addr = 32'h1c000008; #1;
    chk("mid_ram_en", 128'(ram_en), 128'(1));
    tick;
    inst_addr = 32'h1c000014; #1;
    chk("mid2_ram_addr", 128'(ram_addr), 128'(1));
    tick;
    inst_req = 1'b0; #1;
    chk("mid_valid", 128'(inst_valid), 128'(1));
    chk("mid_rdata", inst_rdata, {64'h0, iw(0, 3), iw(0, 2)});
    chk("mid_count", 128'(inst_count), 128'(1));
    tick;
    chk("mid2_valid", 128'(inst_valid), 128'(1));
    chk("mid2_rdata", inst_rdata, {32'h0, iw(1, 3), iw(1, 2), iw(1, 1)});
    chk("mid2_count", 128'(inst_count), 128'(2));
    tick;
    chk("mid_valid_end", 128'(inst_valid), 128'(0));

    // last RAM word, then out-of-range, misaligned and uncached-region faults
    inst_req = 1'b1; inst_addr = 32'h1c00fffc; #1;
    chk("last_ram_en", 128'(ram_en), 128'(1));
    chk("last_ram_addr", 128'(ram_addr), 128'(12'hfff));
    tick;
    inst_addr = 32'h1c010000; #1;
    chk("oor_ram_en", 128'(ram_en), 128'(0));
    chk("oor_addr_ok", 128'(inst_addr_ok), 128'(1));
    tick;
    inst_addr = 32'h1c000002; #1;
    chk("mis_ram_en", 128'(ram_en), 128'(0));
    chk("last_valid", 128'(inst_valid), 128'(1));
    chk("last_rdata", inst_rdata, {96'h0, iw(4095, 3)});
    chk("last_count", 128'(inst_count), 128'(0));
    chk("last_exc", 128'(inst_exception), 128'(0));
    tick;
    inst_addr = 32'h1f000000; #1;
    chk("unc_ram_en", 128'(ram_en), 128'(0));
    chk("oor_valid", 128'(inst_valid), 128'(1));
    chk("oor_exc", 128'(inst_exception), 128'(1));
    chk("oor_code", 128'(inst_exccode), 128'(6'h08));
    chk("oor_rdata", inst_rdata, 128'(0));
    tick;
    inst_req = 1'b0; #1;
    chk("mis_valid", 128'(inst_valid), 128'(1));
    chk("mis_exc", 128'(inst_exception), 128'(1));
    chk("mis_code", 128'(inst_exccode), 128'(6'h08));
    chk("mis_rdata", inst_rdata, 128'(0));
    chk("mis_unc", 128'(inst_uncache), 128'(0));
    tick;
    chk("unc_valid", 128'(inst_valid), 128'(1));
    chk("unc_exc", 128'(inst_exception), 128'(1));
    chk("unc_unc", 128'(inst_uncache), 128'(1));
    tick;
    chk("flt_valid_end", 128'(inst_valid), 128'(0));

    // cancel with two fetches in flight
    inst_req = 1'b1; inst_addr = 32'h1c000000;
    tick;
    inst_addr = 32'h1c000004;
    tick;
    inst_addr = 32'h1c000008; inst_cancel = 1'b1; #1;
    chk("can_valid_c", 128'(inst_valid), 128'(0));
    chk("can_addr_ok", 128'(inst_addr_ok), 128'(0));
    chk("can_ram_en", 128'(ram_en), 128'(0));
    tick;
    inst_cancel = 1'b0; inst_addr = 32'h1c00000c; #1;
    chk("can_valid_c1", 128'(inst_valid), 128'(0));
    chk("can_addr_ok_c1", 128'(inst_addr_ok), 128'(1));
    tick;
    inst_req = 1'b0; #1;
    chk("can_valid_c2", 128'(inst_valid), 128'(0));
    tick;
    chk("can_valid_c3", 128'(inst_valid), 128'(1));
    chk("can_rdata", inst_rdata, {96'h0, iw(0, 3)});
    chk("can_count", 128'(inst_count), 128'(0));
    tick;
    chk("can_valid_end", 128'(inst_valid), 128'(0));

    // reset with a fetch in flight
    inst_req = 1'b1; inst_addr = 32'h1c000010;
    tick;
    inst_req = 1'b0; reset = 1'b1; #1;
    chk("rmf_valid_t1", 128'(inst_valid), 128'(0));
    chk("rmf_addr_ok", 128'(inst_addr_ok), 128'(0));
    tick;
    chk("rmf_valid_t2", 128'(inst_valid), 128'(0));
    chk("rmf_rdata", inst_rdata, 128'(0));
    chk("rmf_count", 128'(inst_count), 128'(0));
    chk("rmf_exc", 128'(inst_exception), 128'(0));
    reset = 1'b0;
    tick;
    chk("rmf_valid_t3", 128'(inst_valid), 128'(0));
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
